// File: rtl/drum_pkg.sv
// Shared widths, FSM encoding and fixed-point helpers for the drum column solver.
package drum_pkg;
    localparam int DRUM_DW        = 18;
    localparam int DRUM_FRAC      = 17;
    localparam int DRUM_ETA_SHIFT = 10;
    localparam int WIDE           = 48;

    typedef logic signed [WIDE-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    // alpha * x with alpha = 1 - 2^-sh; the arithmetic shift floors toward -inf
    function automatic wide_t damp(input wide_t x, input int sh);
        return x - (x >>> sh);
    endfunction

    function automatic wide_t saturate(input wide_t x, input int dw);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction
endpackage

// File: rtl/drum_column_solver_if.sv
// Control, init, tap and neighbour-exchange signals of one drum column node.
interface drum_column_solver_if #(
    parameter int AW = 5,
    parameter int DW = 18
);
    logic                 start;
    logic [DW-1:0]        rho;
    logic                 init_we;
    logic [AW-1:0]        init_addr;
    logic signed [DW-1:0] init_data;
    logic [AW-1:0]        tap_row;
    logic signed [DW-1:0] left_un;
    logic signed [DW-1:0] right_un;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        row_idx;
    logic signed [DW-1:0] un_out;
    logic signed [DW-1:0] tap_out;

    modport master (
        output start, rho, init_we, init_addr, init_data, tap_row, left_un, right_un,
        input  busy, done, row_idx, un_out, tap_out
    );

    modport slave (
        input  start, rho, init_we, init_addr, init_data, tap_row, left_un, right_un,
        output busy, done, row_idx, un_out, tap_out
    );
endinterface

// File: rtl/drum_col_ram.sv
// Simple dual-port RAM, one write and one read port, M10K style.
// Latency: registered read, data one cycle after the address; same-address read returns old data.
// Backpressure: none, accepts a read and a write every cycle.
module drum_col_ram #(
    parameter int AW = 5,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/drum_column_solver.sv
// Damped wave-equation column node: advances ROWS nodes one time step per start, one row per cycle.
// Latency: start sampled at cycle t gives a done pulse at t+ROWS+3.
// Backpressure: start and init_we are ignored while busy.
module drum_column_solver
    import drum_pkg::*;
#(
    parameter int ROWS      = 30,
    parameter int AW        = 5,
    parameter int DW        = DRUM_DW,
    parameter int FRAC      = DRUM_FRAC,
    parameter int ETA_SHIFT = DRUM_ETA_SHIFT
) (
    input logic clk,
    input logic rst,
    drum_column_solver_if.slave bus
);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_t               state;
    logic                 fill_cnt;
    logic [AW-1:0]        row_r;
    logic                 busy_r;
    logic                 done_r;
    logic signed [DW-1:0] tap_r;
    logic signed [DW-1:0] down;
    logic signed [DW-1:0] ctr;

    logic signed [DW-1:0] un_q;
    logic signed [DW-1:0] nm1_q;
    logic [AW-1:0]        un_raddr;
    logic [AW-1:0]        nm1_raddr;
    logic [AW-1:0]        waddr;
    logic                 run_wr;
    logic                 idle_wr;
    logic                 ram_we;
    logic signed [DW-1:0] un_wdata;
    logic signed [DW-1:0] nm1_wdata;

    logic                 last_row;
    logic signed [DW-1:0] up;
    logic signed [DW-1:0] u_np1;
    wide_t                lap;
    wide_t                prod;
    wide_t                tmp3;

    // u_n is read two rows ahead so its output register serves as the "up" tap;
    // u_nm1 is read one row ahead. Both stay ahead of the row being written.
    always_comb begin
        un_raddr  = '0;
        nm1_raddr = '0;
        case (state)
            ST_FILL: un_raddr = fill_cnt ? AW'(1) : '0;
            ST_RUN: begin
                un_raddr  = row_r + AW'(2);
                nm1_raddr = row_r + AW'(1);
            end
            default: ;
        endcase
    end

    // A reset in the same cycle suppresses the row write, so an aborted step stops cleanly.
    assign run_wr    = (state == ST_RUN) && !rst;
    assign idle_wr   = (state == ST_IDLE) && bus.init_we && !rst;
    assign ram_we    = run_wr || idle_wr;
    assign waddr     = run_wr ? row_r : bus.init_addr;
    assign un_wdata  = run_wr ? u_np1 : bus.init_data;
    assign nm1_wdata = run_wr ? ctr : bus.init_data;

    drum_col_ram #(.AW(AW), .DW(DW)) u_un_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (un_wdata),
        .raddr (un_raddr),
        .rdata (un_q)
    );

    drum_col_ram #(.AW(AW), .DW(DW)) u_nm1_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (nm1_wdata),
        .raddr (nm1_raddr),
        .rdata (nm1_q)
    );

    assign last_row = (row_r == LAST_ROW);
    assign up       = last_row ? '0 : un_q;

    always_comb begin
        lap   = wide_t'(bus.left_un) + wide_t'(bus.right_un) + wide_t'(up) + wide_t'(down)
              - (wide_t'(ctr) <<< 2);
        prod  = (wide_t'(bus.rho) * lap) >>> FRAC;
        tmp3  = (wide_t'(ctr) <<< 1) + prod - damp(wide_t'(nm1_q), ETA_SHIFT);
        u_np1 = DW'(saturate(damp(tmp3, ETA_SHIFT), DW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fill_cnt <= 1'b0;
            row_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tap_r    <= '0;
            down     <= '0;
            ctr      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_FILL;
                        fill_cnt <= 1'b0;
                        row_r    <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                ST_FILL: begin
                    fill_cnt <= 1'b1;
                    if (fill_cnt) begin
                        state <= ST_RUN;
                        ctr   <= un_q;
                        down  <= '0;
                    end
                end
                ST_RUN: begin
                    down <= ctr;
                    ctr  <= up;
                    if (row_r == bus.tap_row) tap_r <= u_np1;
                    if (last_row) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end else begin
                        row_r <= row_r + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.row_idx = row_r;
    assign bus.un_out  = ctr;
    assign bus.tap_out = tap_r;
endmodule
